// File: rtl/main_memory_responder.sv
// Main-memory responder: single-cycle strobe requests, fixed wait states, then one MReady pulse.
// Optional address-range checking with MErr is enabled by defining MEM_ADDR_CHECK_EN.
module main_memory_responder #(
  parameter int AW          = 16,
  parameter int DW          = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MStrobe,
  input  logic          MRW,
  input  logic [AW-1:0] MAddr,
  input  logic [DW-1:0] MDataIn,
  output logic [DW-1:0] MDataOut,
  output logic          MReady,
  output logic          MBusy
`ifdef MEM_ADDR_CHECK_EN
  , output logic        MErr
`endif
);

  // state  | meaning
  // S_IDLE | waiting for MStrobe
  // S_WAIT | counting down wait states
  // S_DONE | access performed, MReady high
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam int         IW        = $clog2(DEPTH);
  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES);

  state_t          state, state_next;
  logic [7:0]      cnt;
  logic            req_rw;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_data;
  logic            accept;
  logic            enter_done;
  logic            acc_rw;
  logic [AW-1:0]   acc_addr;
  logic [DW-1:0]   acc_data;
  logic [IW-1:0]   idx;
  logic            addr_bad;
  logic [DW-1:0]   mem [DEPTH];

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (MStrobe) state_next = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      S_WAIT: if (cnt <= 8'd1) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge, so use the live inputs.
  assign accept     = (state == S_IDLE) && MStrobe;
  assign enter_done = (state_next == S_DONE);
  assign acc_rw     = (state == S_IDLE) ? MRW     : req_rw;
  assign acc_addr   = (state == S_IDLE) ? MAddr   : req_addr;
  assign acc_data   = (state == S_IDLE) ? MDataIn : req_data;
  assign idx        = acc_addr[IW-1:0];

`ifdef MEM_ADDR_CHECK_EN
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  assign addr_bad = ({1'b0, acc_addr} >= DEPTH_W);
`else
  // Upper address bits alias onto the array.
  logic unused_addr;
  assign unused_addr = ^acc_addr;
  assign addr_bad    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      req_rw   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      MReady   <= 1'b0;
      MBusy    <= 1'b0;
      MDataOut <= '0;
`ifdef MEM_ADDR_CHECK_EN
      MErr     <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      MReady <= enter_done;
      MBusy  <= (state_next != S_IDLE);
      if (accept) begin
        req_rw   <= MRW;
        req_addr <= MAddr;
        req_data <= MDataIn;
        cnt      <= WAIT_LOAD;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 8'd1;
      end
      if (enter_done && !acc_rw)
        MDataOut <= addr_bad ? '0 : mem[idx];
`ifdef MEM_ADDR_CHECK_EN
      MErr <= enter_done && addr_bad;
`endif
    end
  end

  // Array is never reset; a write still in flight when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (!reset && enter_done && acc_rw && !addr_bad)
      mem[idx] <= acc_data;
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: a WAIT_CYCLES=4 instance and a WAIT_CYCLES=0 instance.
// Address-check expectations follow MEM_ADDR_CHECK_EN when it is defined.
module tb_main_memory_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        s_strobe, s_rw, z_strobe, z_rw;
  logic [15:0] s_addr, z_addr;
  logic [31:0] s_din, z_din, s_dout, z_dout;
  logic        s_rdy, s_busy, s_err, z_rdy, z_busy, z_err;

  main_memory_responder #(.AW(16), .DW(32), .DEPTH(1024), .WAIT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .MStrobe(s_strobe), .MRW(s_rw), .MAddr(s_addr),
    .MDataIn(s_din), .MDataOut(s_dout), .MReady(s_rdy), .MBusy(s_busy)
`ifdef MEM_ADDR_CHECK_EN
    , .MErr(s_err)
`endif
  );

  main_memory_responder #(.AW(16), .DW(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .MStrobe(z_strobe), .MRW(z_rw), .MAddr(z_addr),
    .MDataIn(z_din), .MDataOut(z_dout), .MReady(z_rdy), .MBusy(z_busy)
`ifdef MEM_ADDR_CHECK_EN
    , .MErr(z_err)
`endif
  );

`ifndef MEM_ADDR_CHECK_EN
  assign s_err = 1'b0;
  assign z_err = 1'b0;
`endif

  logic        sel;
  logic        c_rdy, c_busy, c_err;
  logic [31:0] c_dout;
  assign c_rdy  = sel ? z_rdy  : s_rdy;
  assign c_busy = sel ? z_busy : s_busy;
  assign c_err  = sel ? z_err  : s_err;
  assign c_dout = sel ? z_dout : s_dout;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One request on the selected instance; returns cycles from the acceptance edge to MReady.
  task automatic txn(input logic rw, input logic [15:0] a, input logic [31:0] d,
                     output int lat, output logic busy_ok);
    @(negedge clk);
    if (sel) begin z_strobe = 1'b1; z_rw = rw; z_addr = a; z_din = d; end
    else     begin s_strobe = 1'b1; s_rw = rw; s_addr = a; s_din = d; end
    @(posedge clk);
    #1;
    s_strobe = 1'b0;
    z_strobe = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!c_busy) busy_ok = 1'b0;
      if (c_rdy) begin lat = i; break; end
    end
  endtask

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] exp_dout;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int   lat, gap, hits;
    logic bok;
    logic chk_en;
`ifdef MEM_ADDR_CHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 16'h0011, 32'h00000001, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b0, 16'h0011, 32'h0,        32'h00000001, 1'b0};
    vecs[4] = '{1'b1, 16'h03FF, 32'hA5A5A5A5, 32'h00000001, 1'b0};
    vecs[5] = '{1'b0, 16'h03FF, 32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[6] = '{1'b1, 16'h0000, 32'h11111111, 32'hA5A5A5A5, 1'b0};
    vecs[7] = '{1'b1, 16'h0400, 32'hCAFEF00D, 32'hA5A5A5A5, chk_en};
    vecs[8] = '{1'b0, 16'h0000, 32'h0, chk_en ? 32'h11111111 : 32'hCAFEF00D, 1'b0};
    vecs[9] = '{1'b0, 16'h0400, 32'h0, chk_en ? 32'h00000000 : 32'hCAFEF00D, chk_en};

    sel = 1'b0;
    reset = 1'b1;
    s_strobe = 1'b0; s_rw = 1'b0; s_addr = '0; s_din = '0;
    z_strobe = 1'b0; z_rw = 1'b0; z_addr = '0; z_din = '0;
    repeat (2) @(posedge clk);
    #1;
    s_strobe = 1'b1; s_rw = 1'b1; s_addr = 16'h0010; s_din = 32'h77777777;
    @(posedge clk);
    #1;
    reset = 1'b0;
    s_strobe = 1'b0;

    @(negedge clk);
    check("rst_ready", {31'b0, s_rdy}, 32'd0);
    check("rst_busy",  {31'b0, s_busy}, 32'd0);
    check("rst_dout",  s_dout, 32'd0);
    check("rst_err",   {31'b0, s_err}, 32'd0);
    check("rst_dout0", z_dout, 32'd0);
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_rdy || s_busy || z_rdy) hits++;
    end
    check("idle_quiet", hits, 0);

    for (int i = 0; i < 10; i++) begin
      txn(vecs[i].rw, vecs[i].addr, vecs[i].data, lat, bok);
      check($sformatf("v%0d_latency", i), lat, 5);
      check($sformatf("v%0d_busy", i), {31'b0, bok}, 32'd1);
      check($sformatf("v%0d_dout", i), c_dout, vecs[i].exp_dout);
      check($sformatf("v%0d_err", i), {31'b0, c_err}, {31'b0, vecs[i].exp_err});
      @(negedge clk);
      check($sformatf("v%0d_ready_low", i), {31'b0, c_rdy}, 32'd0);
      check($sformatf("v%0d_busy_low", i), {31'b0, c_busy}, 32'd0);
      check($sformatf("v%0d_err_low", i), {31'b0, c_err}, 32'd0);
      check($sformatf("v%0d_dout_held", i), c_dout, vecs[i].exp_dout);
    end

    // Strobe held high through WAIT with other address/data: must be ignored.
    txn(1'b1, 16'h0031, 32'h0, lat, bok);
    @(negedge clk);
    s_strobe = 1'b1; s_rw = 1'b1; s_addr = 16'h0030; s_din = 32'h00000055;
    @(posedge clk);
    #1;
    s_addr = 16'h0031; s_din = 32'h00000066;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (s_rdy) begin lat = i; break; end
    end
    check("hold_latency", lat, 5);
    s_rw = 1'b0; s_addr = 16'h0030;
    @(negedge clk);
    check("hold_idle_gap", {31'b0, s_busy}, 32'd0);
    @(posedge clk);
    #1;
    s_strobe = 1'b0;
    gap = 0;
    for (int i = 2; i <= 25; i++) begin
      @(negedge clk);
      if (s_rdy) begin gap = i; break; end
    end
    check("hold_ready_gap", gap, 6);
    check("hold_first_write", s_dout, 32'h00000055);
    txn(1'b0, 16'h0031, 32'h0, lat, bok);
    check("hold_ignored_write", s_dout, 32'h00000000);

    // Reset during the second WAIT cycle of a write.
    txn(1'b1, 16'h0020, 32'h0BAD0BAD, lat, bok);
    @(negedge clk);
    s_strobe = 1'b1; s_rw = 1'b1; s_addr = 16'h0020; s_din = 32'h12345678;
    @(posedge clk);
    #1;
    s_strobe = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, s_busy}, 32'd0);
    check("abort_dout", s_dout, 32'd0);
    hits = 0;
    repeat (10) begin
      if (s_rdy) hits++;
      @(negedge clk);
    end
    check("abort_no_ready", hits, 0);
    txn(1'b0, 16'h0020, 32'h0, lat, bok);
    check("abort_untouched", s_dout, 32'h0BAD0BAD);
    txn(1'b1, 16'h0020, 32'h0, lat, bok);
    txn(1'b0, 16'h0020, 32'h0, lat, bok);
    check("abort_rewrite", s_dout, 32'h00000000);

    // Zero wait states.
    sel = 1'b1;
    txn(1'b1, 16'h0005, 32'hABCD1234, lat, bok);
    check("w0_wr_latency", lat, 1);
    check("w0_wr_busy", {31'b0, bok}, 32'd1);
    @(negedge clk);
    check("w0_wr_busy_low", {31'b0, z_busy}, 32'd0);
    txn(1'b0, 16'h0005, 32'h0, lat, bok);
    check("w0_rd_latency", lat, 1);
    check("w0_rd_dout", z_dout, 32'hABCD1234);
    @(negedge clk);
    check("w0_rd_busy_low", {31'b0, z_busy}, 32'd0);
    check("w0_rd_held", z_dout, 32'hABCD1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
